// File: rtl/bit_serial_subtractor_if.sv
// Handshake and operand/result bundle for bit_serial_subtractor.
//   start  : request, sampled only while the subtractor is idle
//   A, B   : minuend / subtrahend, index 0 = MSB, index WIDTH-1 = LSB
//   Bin    : borrow-in
//   busy   : high while the operation is running
//   done   : one-cycle pulse, D/Bout/V valid
//   D      : difference (same bit order as A)
//   Bout   : final borrow, V : signed overflow
// master = requester side, slave = subtractor side.
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [0:WIDTH-1] A;
  logic [0:WIDTH-1] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [0:WIDTH-1] D;
  logic             Bout;
  logic             V;

  modport master (output start, A, B, Bin, input busy, done, D, Bout, V);
  modport slave  (input start, A, B, Bin, output busy, done, D, Bout, V);
endinterface

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock, LSB first,
// using a single full-subtractor cell and a registered borrow.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low
//   bus   : bit_serial_subtractor_if.slave (start/busy/done, A/B/Bin, D/Bout/V)
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit per edge, WIDTH edges total
// DONE  | one cycle, done=1, results valid
module bit_serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bit_serial_subtractor_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [0:WIDTH-1] sa, sb, res, d_q;
  logic             br, bout_q, v_q;
  logic             a_msb, b_msb;
  logic [CNT_W-1:0] cnt;
  logic             a_bit, b_bit, d_bit, br_nxt, last_bit;

  // LSB lives at the high index
  assign a_bit    = sa[WIDTH-1];
  assign b_bit    = sb[WIDTH-1];
  assign d_bit    = a_bit ^ b_bit ^ br;
  assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      d_q    <= '0;
      br     <= 1'b0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa    <= bus.A;
            sb    <= bus.B;
            br    <= bus.Bin;
            a_msb <= bus.A[0];
            b_msb <= bus.B[0];
            cnt   <= '0;
          end
        end
        RUN: begin
          // shift toward the LSB; result enters at the MSB end so each bit
          // lands at its original index after WIDTH shifts
          sa  <= {1'b0, sa[0:WIDTH-2]};
          sb  <= {1'b0, sb[0:WIDTH-2]};
          res <= {d_bit, res[0:WIDTH-2]};
          br  <= br_nxt;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            // d_bit here is the result MSB
            d_q    <= {d_bit, res[0:WIDTH-2]};
            bout_q <= br_nxt;
            v_q    <= (a_msb != b_msb) && (d_bit != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;

endmodule
